execute_mc: RTL and testbench
=============================

EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits.
REQ-002 Parameter REGW, default 5: register-specifier width in bits.
REQ-003 Parameter CTRLW, default 9: control-bundle width in bits.
REQ-004 Port clk  in  1: the single clock; every register updates on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port in_valid  in  1: an instruction is present on the inputs.
REQ-007 Port reg_lock  in  1: downstream stall; freezes all output registers.
REQ-008 Port ctrl  in  CTRLW: control bundle; bit 1 selects imm_ext as ALU operand B.
REQ-009 Port alu_ctrl  in  6: operation code.
REQ-010 Ports busA, busB, imm_ext  in  WIDTH each: register operands and extended immediate.
REQ-011 Ports regA, regB, write_reg  in  REGW each: source and destination specifiers.
REQ-012 Ports write_reg_mem / write_val_mem / reg_write_mem  in  REGW / WIDTH / 1: MEM-stage forward source.
REQ-013 Ports write_reg_wb / write_val_wb / reg_write_wb  in  REGW / WIDTH / 1: WB-stage forward source.
REQ-014 Port busy  out  1: multi-cycle unit occupied; upstream holds its inputs while this is high.
REQ-015 Ports out_valid, ctrl_reg, alu_ctrl_reg, write_reg_reg  out  1, CTRLW, 6, REGW: registered stage outputs.
REQ-016 Ports alu_out_reg, write_data_reg, mult_hi_reg, mult_lo_reg  out  WIDTH each: registered results.

Function
REQ-017 Forwarding: MEM has priority over WB, which has priority over the bus; specifier 0 is never forwarded.
REQ-018 ALU operand B is imm_ext when ctrl[1]=1, otherwise forwarded busB; write_data_reg captures forwarded busB.
REQ-019 Non-multicycle ops: one-cycle latency; outputs load on the edge where in_valid=1, busy=0 and reg_lock=0.
REQ-020 alu_ctrl 6'h0e is a signed multiply and 6'h0f is an unsigned multiply; both use forwarded operands latched on acceptance.
REQ-021 Multiply FSM states: IDLE -> MUL on acceptance; MUL -> DONE after exactly WIDTH cycles (shift-add, 1 bit per cycle); DONE -> IDLE on the first edge with reg_lock=0.
REQ-022 busy SHALL be 1 in MUL and DONE and 0 in IDLE; a new instruction is never accepted while busy=1.
REQ-023 On the DONE -> IDLE edge: mult_hi_reg/mult_lo_reg receive the 2*WIDTH product; alu_out_reg receives the low half; out_valid=1.
REQ-024 While busy=1 and reg_lock=0 (excluding the DONE exit edge), the output registers load a bubble: out_valid=0 and ctrl_reg=0.
REQ-025 reg_lock=1 holds every output register; the FSM counter continues in MUL and waits in DONE.
REQ-026 A signed product is the exact two's-complement result over 2*WIDTH bits, including the case most-negative x most-negative.
REQ-027 When in_valid=0 with busy=0 and reg_lock=0: the registers load a bubble.

Reset
REQ-028 When rst=1 at an edge: FSM -> IDLE, counter=0, and all outputs = 0 (busy=0, out_valid=0); this takes precedence over reg_lock.
REQ-029 A reset during MUL/DONE abandons the operation; no result is ever emitted for it.

Configuration
REQ-030 With EXEC_DIV_EN defined: alu_ctrl 6'h10/6'h11 perform signed/unsigned restoring divide (WIDTH cycles, state DIV).
REQ-031 Divide results: quotient goes to mult_lo_reg and alu_out_reg; remainder goes to mult_hi_reg.
REQ-032 Divide by zero yields quotient all-ones and remainder equal to the dividend.
REQ-033 Without EXEC_DIV_EN: 6'h10/6'h11 are single-cycle ops with result 0, and no divider logic is present.

Structure
REQ-034 Shared package exec_pkg holds: opcode constants (OP_MULS=6'h0e, OP_MULU=6'h0f, OP_DIVS=6'h10, OP_DIVU=6'h11) and the FSM state enum.
REQ-035 The iterative multiply/divide datapath is one sub-module, mdu_iter; the combinational unit alu is reused unchanged.

Verification
REQ-036 ADD with MEM and WB both writing regA=3 (values 5, 9), busB=2 -> alu_out_reg=7 after 1 cycle.
REQ-037 regA=0 while MEM writes r0=0xFFFF -> no forward; busA value is used.
REQ-038 Signed multiply 0xFFFFFFFF x 0x00000002 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, out_valid=1 for 1 cycle.
REQ-039 reg_lock held 5 cycles while in DONE -> outputs frozen, busy stays 1, result emitted on the first edge with reg_lock=0.
REQ-040 rst asserted at MUL cycle 10 -> next cycle busy=0 and out_valid=0; a following ADD completes normally.
REQ-041 With EXEC_DIV_EN: unsigned divide 7/0 -> lo=0xFFFFFFFF, hi=7; signed divide -7/2 -> lo=-3, hi=-1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode constants, the
// multi-cycle FSM state type and opcode classification helpers.
package exec_pkg;

    // Single-cycle ALU operations
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_NOR  = 6'h05;
    localparam logic [5:0] OP_SLT  = 6'h06;
    localparam logic [5:0] OP_SLTU = 6'h07;
    localparam logic [5:0] OP_SLL  = 6'h08;
    localparam logic [5:0] OP_SRL  = 6'h09;
    localparam logic [5:0] OP_SRA  = 6'h0a;

    // Iterative multiply / divide operations
    localparam logic [5:0] OP_MULS = 6'h0e;
    localparam logic [5:0] OP_MULU = 6'h0f;
    localparam logic [5:0] OP_DIVS = 6'h10;
    localparam logic [5:0] OP_DIVU = 6'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } exec_state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MULS) || (op == OP_MULU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == OP_DIVS) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [5:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU. Unknown opcodes produce zero.
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    assign sh = b_i[SHW-1:0];

    // Operation select
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_SLT:  y_o = WIDTH'($signed(a_i) < $signed(b_i));
            OP_SLTU: y_o = WIDTH'(a_i < b_i);
            OP_SLL:  y_o = a_i << sh;
            OP_SRL:  y_o = a_i >> sh;
            OP_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath, one bit per step.
// Multiply is shift-add on operand magnitudes with the sign applied to the
// final 2*WIDTH product, so most-negative x most-negative is exact.
// With EXEC_DIV_EN defined a restoring divider shares the same registers.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start_i,
    input  logic             step_i,
`ifdef EXEC_DIV_EN
    input  logic             div_i,
`endif
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, mcand_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign a_mag  = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag  = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign prod   = {acc_hi_q, acc_lo_q};
    assign prod_s = neg_q ? -prod : prod;

`ifdef EXEC_DIV_EN
    logic             div_q, rneg_q, div0_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // Partial remainder shifted left with the next dividend bit
    assign rs    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign fits  = rs >= {1'b0, mcand_q};
    assign trial = rs[WIDTH-1:0] - mcand_q;
`endif

    // Operand capture on start, one iteration per step
    always_ff @(posedge clk) begin
        if (start_i) begin
            acc_hi_q <= '0;
            neg_q    <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef EXEC_DIV_EN
            div_q    <= div_i;
            rneg_q   <= sgn_i & a_i[WIDTH-1];
            div0_q   <= (b_i == '0);
            dvd_q    <= a_i;
            if (div_i) begin
                acc_lo_q <= a_mag;
                mcand_q  <= b_mag;
            end else begin
                acc_lo_q <= b_mag;
                mcand_q  <= a_mag;
            end
`else
            acc_lo_q <= b_mag;
            mcand_q  <= a_mag;
`endif
        end else if (step_i) begin
`ifdef EXEC_DIV_EN
            if (div_q) begin
                if (fits) begin
                    acc_hi_q <= trial;
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_q <= rs[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_hi_q, acc_lo_q} <= {sum, acc_lo_q[WIDTH-1:1]};
            end
`else
            {acc_hi_q, acc_lo_q} <= {sum, acc_lo_q[WIDTH-1:1]};
`endif
        end
    end

    // Result formatting: signed product, or quotient/remainder with sign fix-up
    always_comb begin
        hi_o = prod_s[2*WIDTH-1:WIDTH];
        lo_o = prod_s[WIDTH-1:0];
`ifdef EXEC_DIV_EN
        if (div_q) begin
            if (div0_q) begin
                lo_o = '1;
                hi_o = dvd_q;
            end else begin
                lo_o = neg_q  ? -acc_lo_q : acc_lo_q;
                hi_o = rneg_q ? -acc_hi_q : acc_hi_q;
            end
        end
`endif
    end

endmodule

// File: rtl/execute_mc.sv
// Execute stage with operand forwarding, single-cycle ALU and an iterative
// multiply unit (WIDTH cycles). Optional macro EXEC_DIV_EN adds an iterative
// signed/unsigned divide through the same unit.
module execute_mc
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             reg_lock,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [REGW-1:0]  regA,
    input  logic [REGW-1:0]  regB,
    input  logic [REGW-1:0]  write_reg,
    input  logic [REGW-1:0]  write_reg_mem,
    input  logic [WIDTH-1:0] write_val_mem,
    input  logic             reg_write_mem,
    input  logic [REGW-1:0]  write_reg_wb,
    input  logic [WIDTH-1:0] write_val_wb,
    input  logic             reg_write_wb,
    output logic             busy,
    output logic             out_valid,
    output logic [CTRLW-1:0] ctrl_reg,
    output logic [5:0]       alu_ctrl_reg,
    output logic [REGW-1:0]  write_reg_reg,
    output logic [WIDTH-1:0] alu_out_reg,
    output logic [WIDTH-1:0] write_data_reg,
    output logic [WIDTH-1:0] mult_hi_reg,
    output logic [WIDTH-1:0] mult_lo_reg
);

    localparam int             CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    exec_state_e      state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             start, step, accept, mdu_op, mdu_go, done_exit;

    logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_y, res_y, md_hi, md_lo;

    logic [CTRLW-1:0] pend_ctrl_q;
    logic [5:0]       pend_op_q;
    logic [REGW-1:0]  pend_wreg_q;
    logic [WIDTH-1:0] pend_wdata_q;

    logic             out_valid_q;
    logic [CTRLW-1:0] ctrl_q;
    logic [5:0]       alu_ctrl_q;
    logic [REGW-1:0]  write_reg_q;
    logic [WIDTH-1:0] alu_out_q, write_data_q, hi_q, lo_q;

    // Forwarding: MEM overrides WB overrides the bus; r0 never forwards
    always_comb begin
        fwd_a = busA;
        fwd_b = busB;
        if (regA != '0 && reg_write_wb  && write_reg_wb  == regA) fwd_a = write_val_wb;
        if (regA != '0 && reg_write_mem && write_reg_mem == regA) fwd_a = write_val_mem;
        if (regB != '0 && reg_write_wb  && write_reg_wb  == regB) fwd_b = write_val_wb;
        if (regB != '0 && reg_write_mem && write_reg_mem == regB) fwd_b = write_val_mem;
    end

    assign op_b = ctrl[1] ? imm_ext : fwd_b;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op_i (alu_ctrl),
        .a_i  (fwd_a),
        .b_i  (op_b),
        .y_o  (alu_y)
    );

`ifdef EXEC_DIV_EN
    assign mdu_op = is_mul_op(alu_ctrl) || is_div_op(alu_ctrl);
    assign res_y  = alu_y;
`else
    assign mdu_op = is_mul_op(alu_ctrl);
    assign res_y  = is_div_op(alu_ctrl) ? '0 : alu_y;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign accept    = in_valid && (state_q == ST_IDLE) && !reg_lock;
    assign mdu_go    = accept && mdu_op;
    assign done_exit = (state_q == ST_DONE) && !reg_lock;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk     (clk),
        .start_i (start),
        .step_i  (step),
`ifdef EXEC_DIV_EN
        .div_i   (is_div_op(alu_ctrl)),
`endif
        .sgn_i   (is_signed_md(alu_ctrl)),
        .a_i     (fwd_a),
        .b_i     (fwd_b),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // FSM state and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; the counter keeps running in MUL/DIV even under reg_lock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mdu_go) begin
                    start = 1'b1;
                    cnt_d = '0;
`ifdef EXEC_DIV_EN
                    state_d = is_div_op(alu_ctrl) ? ST_DIV : ST_MUL;
`else
                    state_d = ST_MUL;
`endif
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DONE: begin
                if (!reg_lock) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Side-band of a multi-cycle instruction, replayed with its result
    always_ff @(posedge clk) begin
        if (mdu_go) begin
            pend_ctrl_q  <= ctrl;
            pend_op_q    <= alu_ctrl;
            pend_wreg_q  <= write_reg;
            pend_wdata_q <= fwd_b;
        end
    end

    // Stage output registers: result, single-cycle load, or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            ctrl_q       <= '0;
            alu_ctrl_q   <= '0;
            write_reg_q  <= '0;
            alu_out_q    <= '0;
            write_data_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else if (!reg_lock) begin
            if (done_exit) begin
                out_valid_q  <= 1'b1;
                ctrl_q       <= pend_ctrl_q;
                alu_ctrl_q   <= pend_op_q;
                write_reg_q  <= pend_wreg_q;
                alu_out_q    <= md_lo;
                write_data_q <= pend_wdata_q;
                hi_q         <= md_hi;
                lo_q         <= md_lo;
            end else if (accept && !mdu_op) begin
                out_valid_q  <= 1'b1;
                ctrl_q       <= ctrl;
                alu_ctrl_q   <= alu_ctrl;
                write_reg_q  <= write_reg;
                alu_out_q    <= res_y;
                write_data_q <= fwd_b;
            end else begin
                out_valid_q  <= 1'b0;
                ctrl_q       <= '0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign ctrl_reg       = ctrl_q;
    assign alu_ctrl_reg   = alu_ctrl_q;
    assign write_reg_reg  = write_reg_q;
    assign alu_out_reg    = alu_out_q;
    assign write_data_reg = write_data_q;
    assign mult_hi_reg    = hi_q;
    assign mult_lo_reg    = lo_q;

endmodule

// File: tb/tb_execute_mc.sv
// Scoreboard bench for execute_mc: the driver pushes the expected result of
// each accepted instruction; a negedge monitor pops and compares every new
// output, checks bubbles and that reg_lock freezes the output registers.
module tb_execute_mc;
    import exec_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, reg_lock = 1'b0;
    logic [8:0]  ctrl = '0;
    logic [5:0]  alu_ctrl = '0;
    logic [31:0] busA = '0, busB = '0, imm_ext = '0;
    logic [4:0]  regA = '0, regB = '0, write_reg = '0;
    logic [4:0]  write_reg_mem = '0, write_reg_wb = '0;
    logic [31:0] write_val_mem = '0, write_val_wb = '0;
    logic        reg_write_mem = 1'b0, reg_write_wb = 1'b0;

    logic        busy, out_valid;
    logic [8:0]  ctrl_reg;
    logic [5:0]  alu_ctrl_reg;
    logic [4:0]  write_reg_reg;
    logic [31:0] alu_out_reg, write_data_reg, mult_hi_reg, mult_lo_reg;

    execute_mc #(.WIDTH(32), .REGW(5), .CTRLW(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .reg_lock(reg_lock),
        .ctrl(ctrl), .alu_ctrl(alu_ctrl), .busA(busA), .busB(busB),
        .imm_ext(imm_ext), .regA(regA), .regB(regB), .write_reg(write_reg),
        .write_reg_mem(write_reg_mem), .write_val_mem(write_val_mem),
        .reg_write_mem(reg_write_mem), .write_reg_wb(write_reg_wb),
        .write_val_wb(write_val_wb), .reg_write_wb(reg_write_wb),
        .busy(busy), .out_valid(out_valid), .ctrl_reg(ctrl_reg),
        .alu_ctrl_reg(alu_ctrl_reg), .write_reg_reg(write_reg_reg),
        .alu_out_reg(alu_out_reg), .write_data_reg(write_data_reg),
        .mult_hi_reg(mult_hi_reg), .mult_lo_reg(mult_lo_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, wdata, hi, lo;
        logic [8:0]  ctrl;
        logic [5:0]  aop;
        logic [4:0]  wreg;
        bit          md;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic [5:0] ops [16];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] bus);
        if (r != 0 && reg_write_mem && write_reg_mem == r) return write_val_mem;
        if (r != 0 && reg_write_wb && write_reg_wb == r) return write_val_wb;
        return bus;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_md(input logic [5:0] op);
`ifdef EXEC_DIV_EN
        return op == OP_MULS || op == OP_MULU || op == OP_DIVS || op == OP_DIVU;
`else
        return op == OP_MULS || op == OP_MULU;
`endif
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] md_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            OP_MULS: p = sa * sb;
            OP_MULU: p = {32'd0, a} * {32'd0, b};
`ifdef EXEC_DIV_EN
            OP_DIVS: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    qq = sa / sb; rr = sa % sb;
                    qv = qq; rv = rr;
                    p = {rv[31:0], qv[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
`endif
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic push_expected();
        exp_t e;
        logic [31:0] a, b;
        logic [63:0] hm;
        a = fwd(regA, busA);
        b = fwd(regB, busB);
        e.ctrl = ctrl; e.aop = alu_ctrl; e.wreg = write_reg; e.wdata = b;
        if (is_md(alu_ctrl)) begin
            hm = md_ref(alu_ctrl, a, b);
            e.md = 1'b1; e.hi = hm[63:32]; e.lo = hm[31:0]; e.alu = hm[31:0];
        end else begin
            e.md = 1'b0; e.hi = '0; e.lo = '0;
            e.alu = alu_ref(alu_ctrl, a, ctrl[1] ? imm_ext : b);
        end
        q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycle(input bit rl);
        in_valid = 1'b0;
        reg_lock = rl ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(posedge clk); #1;
        reg_lock = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [8:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] wr, input bit rl);
        bit acc;
        int n;
        alu_ctrl = op; ctrl = c; busA = a; busB = b; imm_ext = imm;
        regA = ra; regB = rb; write_reg = wr; in_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            reg_lock = rl ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc = !busy && !reg_lock;
            if (acc) push_expected();
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        reg_lock = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic clr_fwd();
        reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        write_reg_mem = '0; write_reg_wb = '0;
        write_val_mem = '0; write_val_wb = '0;
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (q.size() != 0 && n < lim) begin
            idle_cycle(1'b0);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    logic         rst_e  = 1'b1;
    logic         lock_e = 1'b0;
    logic [148:0] cur;
    logic [148:0] prev = '0;

    assign cur = {out_valid, ctrl_reg, alu_ctrl_reg, write_reg_reg,
                  alu_out_reg, write_data_reg, mult_hi_reg, mult_lo_reg};

    always @(posedge clk) begin
        rst_e  <= rst;
        lock_e <= reg_lock;
    end

    task automatic check_out();
        exp_t e;
        chk("queue_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("alu_out", alu_out_reg, e.alu);
            chk("write_data", write_data_reg, e.wdata);
            chk("ctrl_reg", ctrl_reg, e.ctrl);
            chk("alu_ctrl_reg", alu_ctrl_reg, e.aop);
            chk("write_reg_reg", write_reg_reg, e.wreg);
            if (e.md) begin
                chk("mult_hi", mult_hi_reg, e.hi);
                chk("mult_lo", mult_lo_reg, e.lo);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_e) begin
            if (lock_e) chk("freeze", cur, prev);
            else if (out_valid) check_out();
            else chk("bubble_ctrl", ctrl_reg, 0);
        end
        prev <= cur;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h08, 6'h09, 6'h0a, 6'h0e, 6'h0f, 6'h10, 6'h11, 6'h3f};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_alu_out", alu_out_reg, 0);
        chk("rst_hi", mult_hi_reg, 0);
        chk("rst_lo", mult_lo_reg, 0);
        chk("rst_ctrl", ctrl_reg, 0);
        rst = 1'b0;

        // MEM beats WB on the same register
        reg_write_mem = 1'b1; write_reg_mem = 5'd3; write_val_mem = 32'd5;
        reg_write_wb  = 1'b1; write_reg_wb  = 5'd3; write_val_wb  = 32'd9;
        issue(OP_ADD, 9'h000, 32'd100, 32'd2, 32'd0, 5'd3, 5'd4, 5'd7, 1'b0);
        chk("add_fwd_valid", out_valid, 1);
        chk("add_fwd_value", alu_out_reg, 32'd7);
        clr_fwd();
        idle_cycle(1'b0);
        chk("bubble_valid", out_valid, 0);

        // r0 is never forwarded
        reg_write_mem = 1'b1; write_reg_mem = 5'd0; write_val_mem = 32'h0000_FFFF;
        issue(OP_ADD, 9'h000, 32'h10, 32'h1, 32'd0, 5'd0, 5'd5, 5'd2, 1'b0);
        chk("r0_nofwd", alu_out_reg, 32'h11);
        clr_fwd();

        // Immediate operand select
        issue(OP_ADD, 9'h002, 32'd1, 32'd5, 32'd100, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("imm_sel", alu_out_reg, 32'd101);

        // Signed multiply timing and value
        issue(OP_MULS, 9'h011, 32'hFFFF_FFFF, 32'h2, 32'd0, 5'd1, 5'd2, 5'd6, 1'b0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("mul_busy_cycles", n, 33);
        chk("mul_valid", out_valid, 1);
        chk("mul_hi", mult_hi_reg, 32'hFFFF_FFFF);
        chk("mul_lo", mult_lo_reg, 32'hFFFF_FFFE);
        idle_cycle(1'b0);
        chk("mul_valid_pulse", out_valid, 0);

        // Most-negative squared
        issue(OP_MULS, 9'h000, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd1, 5'd2, 5'd6, 1'b0);
        wait_drain(100);
        chk("minneg_hi", mult_hi_reg, 32'h4000_0000);
        chk("minneg_lo", mult_lo_reg, 32'h0);

        // reg_lock held in DONE
        issue(OP_MULU, 9'h005, 32'd3, 32'd5, 32'd0, 5'd1, 5'd2, 5'd9, 1'b0);
        repeat (32) idle_cycle(1'b0);
        chk("done_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            reg_lock = 1'b1;
            @(posedge clk); #1;
            chk("lock_busy", busy, 1);
            chk("lock_valid", out_valid, 0);
        end
        reg_lock = 1'b0;
        @(posedge clk); #1;
        chk("unlock_valid", out_valid, 1);
        chk("unlock_lo", mult_lo_reg, 32'd15);
        chk("unlock_busy", busy, 0);
        idle_cycle(1'b0);

        // Reset in the middle of a multiply
        issue(OP_MULS, 9'h000, 32'd7, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        repeat (10) idle_cycle(1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_hi", mult_hi_reg, 0);
        issue(OP_ADD, 9'h000, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_add", alu_out_reg, 32'd3);

`ifdef EXEC_DIV_EN
        issue(OP_DIVU, 9'h000, 32'd7, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        wait_drain(100);
        chk("divu0_lo", mult_lo_reg, 32'hFFFF_FFFF);
        chk("divu0_hi", mult_hi_reg, 32'd7);
        issue(OP_DIVS, 9'h000, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        wait_drain(100);
        chk("divs_lo", mult_lo_reg, 32'hFFFF_FFFD);
        chk("divs_hi", mult_hi_reg, 32'hFFFF_FFFF);
`else
        issue(OP_DIVS, 9'h000, 32'd7, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("nodiv_valid", out_valid, 1);
        chk("nodiv_zero", alu_out_reg, 32'd0);
        chk("nodiv_busy", busy, 0);
`endif

        // Randomized mix with forwarding, gaps and reg_lock
        for (int i = 0; i < 60; i++) begin
            write_reg_mem = 5'($urandom_range(0, 7));
            write_val_mem = $urandom;
            reg_write_mem = 1'($urandom_range(0, 1));
            write_reg_wb  = 5'($urandom_range(0, 7));
            write_val_wb  = $urandom;
            reg_write_wb  = 1'($urandom_range(0, 1));
            issue(ops[$urandom_range(0, 15)], 9'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
        end
        wait_drain(2000);
        idle_cycle(1'b0);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
